// File: rtl/soc_memory_pkg.sv
// Shared constants and types for the soc_memory responder: MMIO decode bits,
// UART FSM states and the read-source selector.
package soc_memory_pkg;

    localparam int IO_PAGE_BIT        = 22;
    localparam int IO_LEDS_BIT        = 0;
    localparam int IO_UART_DATA_BIT   = 1;
    localparam int IO_UART_STATUS_BIT = 2;
    localparam int UART_BUSY_BIT      = 9;
    localparam int LED_W              = 5;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef enum logic {
        RD_IO,
        RD_RAM
    } rd_src_e;

    // One-hot MMIO register select on mem_addr[4:2].
    function automatic logic [2:0] io_onehot(input int bit_idx);
        return 3'(1 << bit_idx);
    endfunction

endpackage

// File: rtl/soc_memory_if.sv
// Core-side memory bus: byte address, read strobe, registered read data,
// lane-replicated write data and byte write mask.
interface soc_memory_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    modport master (
        output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/soc_memory_uart_tx.sv
// 8N1 serial transmitter: START, 8 data bits LSB first, STOP; each symbol
// lasts DIV clocks. start is ignored while a frame is in flight.
module uart_tx
    import soc_memory_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          last;

    assign last = (cnt_q == CW'(DIV - 1));
    assign tx   = tx_q;
    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    if (start) begin
                        shift_q <= data;
                        state_q <= UART_START;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                UART_START: begin
                    if (last) begin
                        state_q <= UART_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (last) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= UART_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (last) begin
                        state_q <= UART_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= UART_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/soc_memory.sv
// Memory-side responder: byte-masked word RAM plus an MMIO page with an LED
// register and a UART transmitter. Reads return one cycle after the strobe.
module soc_memory
    import soc_memory_pkg::*;
#(
    parameter int    MEM_WORDS   = 1024,
    parameter string INIT_FILE   = "",
    parameter int    CLK_FREQ_HZ = 12_000_000,
    parameter int    BAUD        = 115_200
) (
    input  logic             clk,
    input  logic             rst,
    soc_memory_if.slave      bus,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int AW  = $clog2(MEM_WORDS);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [31:0]      ram_rdata_q;
    logic [31:0]      io_rdata_q;
    logic [31:0]      io_rdata_d;
    rd_src_e          rd_src_q;
    logic [LED_W-1:0] leds_q;

    logic [AW-1:0] word_idx;
    logic          is_io;
    logic [2:0]    io_sel;
    logic          wr_any;
    logic          uart_start;
    logic          uart_busy;
    logic          unused_bits;

    assign word_idx    = bus.mem_addr[2 +: AW];
    assign is_io       = bus.mem_addr[IO_PAGE_BIT];
    assign io_sel      = bus.mem_addr[4:2];
    assign wr_any      = |bus.mem_wmask;
    assign uart_start  = is_io && wr_any && (io_sel == io_onehot(IO_UART_DATA_BIT));
    assign unused_bits = ^{bus.mem_addr, bus.mem_wdata};

    // No reset here so the array and its output register map onto block RAM.
    // Non-blocking update gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!is_io && bus.mem_wmask[i]) begin
                mem_q[word_idx][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
            end
        end
        if (bus.mem_rstrb) begin
            ram_rdata_q <= mem_q[word_idx];
        end
    end

    always_comb begin
        io_rdata_d = '0;
        if (io_sel == io_onehot(IO_LEDS_BIT)) begin
            io_rdata_d[LED_W-1:0] = leds_q;
        end else if (io_sel == io_onehot(IO_UART_STATUS_BIT)) begin
            io_rdata_d[UART_BUSY_BIT] = uart_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q     <= '0;
            rd_src_q   <= RD_IO;
            io_rdata_q <= '0;
        end else begin
            if (is_io && wr_any && io_sel == io_onehot(IO_LEDS_BIT)) begin
                leds_q <= bus.mem_wdata[LED_W-1:0];
            end
            if (bus.mem_rstrb) begin
                rd_src_q   <= is_io ? RD_IO : RD_RAM;
                io_rdata_q <= is_io ? io_rdata_d : 32'h0;
            end
        end
    end

    assign bus.mem_rdata = (rd_src_q == RD_RAM) ? ram_rdata_q : io_rdata_q;
    assign leds          = leds_q;

    uart_tx #(.DIV(DIV)) u_uart (
        .clk   (clk),
        .rst   (rst),
        .data  (bus.mem_wdata[7:0]),
        .start (uart_start),
        .tx    (uart_tx),
        .busy  (uart_busy)
    );

endmodule

// File: tb/tb_soc_memory.sv
// Randomized bench for soc_memory: RAM traffic against an array model, MMIO
// LED/status reads, and UART frames compared against an 8N1 bit list.
module tb_soc_memory;

    localparam int BAUD = 115_200;
    localparam int DIV  = 4;
    localparam int CLK  = DIV * BAUD;
    localparam int MW   = 256;
    localparam int NW   = 16;

    localparam logic [31:0] A_LEDS   = 32'h0040_0004;
    localparam logic [31:0] A_UDATA  = 32'h0040_0008;
    localparam logic [31:0] A_STATUS = 32'h0040_0010;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] leds;
    logic       uart_tx;

    soc_memory_if bus ();

    soc_memory #(
        .MEM_WORDS   (MW),
        .INIT_FILE   (""),
        .CLK_FREQ_HZ (CLK),
        .BAUD        (BAUD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ref_mem [NW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wmask = m;
        tick;
        idle_bus;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_rstrb = 1'b1;
        tick;
        idle_bus;
        d = bus.mem_rdata;
    endtask

    // Random RAM byte address for model word w: random upper bits alias.
    function automatic logic [31:0] ram_addr(input int w);
        logic [31:0] a;
        a       = $urandom;
        a[22]   = 1'b0;
        a[9:2]  = 8'(w);
        return a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Called just after the edge that accepted byte b: walks the whole frame.
    task automatic check_frame(input logic [7:0] b, input string tag, input bit poke);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        chk({tag, " start"}, 32'(uart_tx), 32'(frame[0]));
        for (int i = 1; i < 10 * DIV; i++) begin
            if (poke && i == 6) begin
                bus.mem_addr  = A_UDATA;
                bus.mem_wdata = 32'h0000_003C;
                bus.mem_wmask = 4'b0001;
            end
            if (poke && i == 13) begin
                bus.mem_addr  = A_STATUS;
                bus.mem_rstrb = 1'b1;
            end
            tick;
            idle_bus;
            if (poke && i == 13) chk({tag, " status busy"}, bus.mem_rdata, 32'h0000_0200);
            chk($sformatf("%s cyc%0d", tag, i), 32'(uart_tx), 32'(frame[i / DIV]));
        end
    endtask

    initial begin
        logic [31:0] d, a, wd;
        logic [3:0]  m;
        logic [7:0]  b;
        int          w, op;

        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        idle_bus;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("reset rdata", bus.mem_rdata, 32'h0);
        chk("reset leds", 32'(leds), 32'h0);
        chk("reset tx", 32'(uart_tx), 32'h1);

        // Directed RAM sequence.
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10, d);
        chk("ram full", d, 32'hDEAD_BEEF);
        wr(32'h12, 32'h5555_5555, 4'b0100);
        rd(32'h10, d);
        chk("ram byte", d, 32'hDE55_BEEF);
        bus.mem_addr  = 32'h10;
        bus.mem_wdata = 32'h1234_5678;
        bus.mem_wmask = 4'hF;
        bus.mem_rstrb = 1'b1;
        tick;
        idle_bus;
        chk("ram rbw old", bus.mem_rdata, 32'hDE55_BEEF);
        rd(32'h10, d);
        chk("ram rbw new", d, 32'h1234_5678);
        wr(32'h20, 32'hCAFE_F00D, 4'hF);
        chk("rdata hold", bus.mem_rdata, 32'h1234_5678);

        // LED register and MMIO decode.
        wr(A_LEDS, 32'h0000_001F, 4'b0001);
        chk("leds pins", 32'(leds), 32'h1F);
        rd(A_LEDS, d);
        chk("leds read", d, 32'h0000_001F);
        wr(A_LEDS, 32'hFFFF_FF0A, 4'b1000);
        chk("leds any mask", 32'(leds), 32'h0A);
        rd(32'h0040_0000, d);
        chk("io none", d, 32'h0);
        rd(32'h0040_001C, d);
        chk("io multihot", d, 32'h0);
        rd(A_UDATA, d);
        chk("udata read", d, 32'h0);
        rd(A_STATUS, d);
        chk("status idle", d, 32'h0);

        // Random RAM traffic against the array model.
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = $urandom;
            wr(ram_addr(i), ref_mem[i], 4'hF);
        end
        for (int n = 0; n < 300; n++) begin
            w  = int'($urandom_range(0, NW - 1));
            op = int'($urandom_range(0, 2));
            a  = ram_addr(w);
            wd = $urandom;
            m  = (op == 1) ? 4'h0 : 4'($urandom);
            bus.mem_addr  = a;
            bus.mem_wdata = wd;
            bus.mem_wmask = m;
            bus.mem_rstrb = (op != 0);
            tick;
            idle_bus;
            if (op != 0) chk($sformatf("rand rd w%0d", w), bus.mem_rdata, ref_mem[w]);
            ref_mem[w] = merge(ref_mem[w], wd, m);
        end

        // UART frame with a dropped write and a busy status read mid-flight.
        wr(A_UDATA, 32'h0000_00A5, 4'b0001);
        check_frame(8'hA5, "frameA5", 1'b1);
        tick;
        chk("stop hold", 32'(uart_tx), 32'h1);
        b = 8'($urandom);
        wr(A_UDATA, {24'h0, b}, 4'b0010);
        check_frame(b, "frame b2b", 1'b0);
        tick;
        tick;
        rd(A_STATUS, d);
        chk("status done", d, 32'h0);

        // Reset during DATA bit 3 aborts the frame; RAM survives.
        b = 8'($urandom) & 8'hF7;
        wr(A_UDATA, {24'h0, b}, 4'b0001);
        for (int i = 0; i < 17; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort tx", 32'(uart_tx), 32'h1);
        chk("abort leds", 32'(leds), 32'h0);
        rd(A_STATUS, d);
        chk("abort status", d, 32'h0);
        w = 3;
        rd(ram_addr(w), d);
        chk("ram after rst", d, ref_mem[w]);
        b = 8'($urandom);
        wr(A_UDATA, {24'h0, b}, 4'b0001);
        check_frame(b, "frame clean", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
